// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the MIPS-lite datapath: FETCH/DECODE/EXE/MEM/WB sequencing.
// Optional macro ILLEGAL_TRAP_EN: unrecognised instructions halt instead of executing as NOP.
module mc_ctrl #(
  parameter int unsigned WAIT_MAX = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic [2:0] npc_sel,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       ext_op,
  output logic       mem_wr,
  output logic [2:0] state,
  output logic       halted,
  output logic       bus_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  state_e state_q, state_d;
  logic   wait_hit;
  logic   bus_err_q;

  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;

  always_comb begin
    is_addu = (opcode == OP_R) && (funct == FN_ADDU);
    is_subu = (opcode == OP_R) && (funct == FN_SUBU);
    is_jr   = (opcode == OP_R) && (funct == FN_JR);
    is_ori  = (opcode == OP_ORI);
    is_lui  = (opcode == OP_LUI);
    is_lw   = (opcode == OP_LW);
    is_sw   = (opcode == OP_SW);
    is_beq  = (opcode == OP_BEQ);
    is_j    = (opcode == OP_J);
    is_jal  = (opcode == OP_JAL);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next state and control fields; a reset cycle forces every output low.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    ir_wr    = 1'b0;
    pc_wr    = 1'b0;
    npc_sel  = 3'b000;
    reg_wr   = 1'b0;
    reg_dst  = 2'b00;
    wd_sel   = 2'b00;
    alu_src  = 1'b0;
    alu_op   = 2'b00;
    ext_op   = 1'b0;
    mem_wr   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_wr   = 1'b1;
            state_d = S_DECODE;
          end else if (wait_hit) begin
            state_d = S_HALT;
          end
        end
        S_DECODE: begin
          if (is_j) begin
            pc_wr   = 1'b1;
            npc_sel = 3'b011;
            state_d = S_FETCH;
          end else if (is_jr) begin
            pc_wr   = 1'b1;
            npc_sel = 3'b100;
            state_d = S_FETCH;
          end else if (is_jal) begin
            reg_wr  = 1'b1;
            reg_dst = 2'b10;
            wd_sel  = 2'b10;
            pc_wr   = 1'b1;
            npc_sel = 3'b010;
            state_d = S_FETCH;
          end else if (is_addu || is_subu || is_ori || is_lui || is_lw || is_sw || is_beq) begin
            state_d = S_EXE;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            pc_wr   = 1'b1;
            npc_sel = 3'b000;
            state_d = S_FETCH;
`endif
          end
        end
        S_EXE: begin
          if (is_addu || is_subu) begin
            alu_op  = is_subu ? 2'b01 : 2'b00;
            state_d = S_WB;
          end else if (is_ori) begin
            alu_src = 1'b1;
            alu_op  = 2'b10;
            state_d = S_WB;
          end else if (is_lui) begin
            alu_src = 1'b1;
            alu_op  = 2'b11;
            state_d = S_WB;
          end else if (is_lw || is_sw) begin
            alu_src = 1'b1;
            ext_op  = 1'b1;
            state_d = S_MEM;
          end else if (is_beq) begin
            alu_op  = 2'b01;
            pc_wr   = 1'b1;
            npc_sel = 3'b001;
            state_d = S_FETCH;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          mem_wr   = is_sw;
          if (dmem_ready) begin
            if (is_sw) begin
              pc_wr   = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (wait_hit) begin
            state_d = S_HALT;
          end
        end
        S_WB: begin
          reg_wr  = 1'b1;
          pc_wr   = 1'b1;
          reg_dst = (opcode == OP_R) ? 2'b01 : 2'b00;
          wd_sel  = is_lw ? 2'b01 : 2'b00;
          state_d = S_FETCH;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    state   = rst ? 3'd0 : 3'(state_q);
    halted  = !rst && (state_q == S_HALT);
    bus_err = !rst && bus_err_q;
  end

  // Wait counter restarts whenever a FETCH/MEM wait run begins.
  if (WAIT_MAX > 0) begin : g_timeout
    localparam int unsigned CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             waiting;
    logic             bus_err_d;

    always_comb begin
      waiting    = ((state_q == S_FETCH) && !imem_ready) || ((state_q == S_MEM) && !dmem_ready);
      wait_hit   = waiting && (wait_cnt_q == CNT_W'(WAIT_MAX - 1));
      wait_cnt_d = waiting ? wait_cnt_q + CNT_W'(1) : '0;
      bus_err_d  = bus_err_q || wait_hit;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wait_cnt_q <= '0;
        bus_err_q  <= 1'b0;
      end else begin
        wait_cnt_q <= wait_cnt_d;
        bus_err_q  <= bus_err_d;
      end
    end
  end else begin : g_no_timeout
    assign wait_hit  = 1'b0;
    assign bus_err_q = 1'b0;
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expected control traces built from the
// instruction table, random instruction mix and wait lengths, plus reset/timeout/illegal cases.
module tb_mc_ctrl;
  localparam int unsigned WAIT_MAX = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       imem_ready, dmem_ready;
  logic       imem_req, dmem_req, ir_wr, pc_wr, reg_wr, alu_src, ext_op, mem_wr, halted, bus_err;
  logic [2:0] npc_sel, state;
  logic [1:0] reg_dst, wd_sel, alu_op;

  always #5 clk = ~clk;

  mc_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_wr(ir_wr), .pc_wr(pc_wr),
    .npc_sel(npc_sel), .reg_wr(reg_wr), .reg_dst(reg_dst), .wd_sel(wd_sel),
    .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op), .mem_wr(mem_wr),
    .state(state), .halted(halted), .bus_err(bus_err)
  );

  typedef enum logic [3:0] {
    K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_ILL
  } kind_e;

  typedef struct packed {
    logic       imem_req, dmem_req, ir_wr, pc_wr;
    logic [2:0] npc_sel;
    logic       reg_wr;
    logic [1:0] reg_dst, wd_sel;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       ext_op, mem_wr;
    logic [2:0] state;
    logic       halted, bus_err;
  } ctl_t;

  typedef struct {
    ctl_t exp;
    logic iready;
    logic dready;
  } step_t;

  step_t trace[$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic ctl_t observe();
    ctl_t o;
    o.imem_req = imem_req; o.dmem_req = dmem_req; o.ir_wr = ir_wr; o.pc_wr = pc_wr;
    o.npc_sel = npc_sel; o.reg_wr = reg_wr; o.reg_dst = reg_dst; o.wd_sel = wd_sel;
    o.alu_src = alu_src; o.alu_op = alu_op; o.ext_op = ext_op; o.mem_wr = mem_wr;
    o.state = state; o.halted = halted; o.bus_err = bus_err;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs_v, exp_v);
    end
  endtask

  function automatic void push(ctl_t c, logic ir, logic dr);
    step_t s;
    s.exp = c; s.iready = ir; s.dready = dr;
    trace.push_back(s);
  endfunction

  task automatic set_ir(input kind_e k);
    funct = 6'($urandom);
    case (k)
      K_ADDU:  begin opcode = 6'b000000; funct = 6'b100001; end
      K_SUBU:  begin opcode = 6'b000000; funct = 6'b100011; end
      K_JR:    begin opcode = 6'b000000; funct = 6'b001000; end
      K_ORI:   opcode = 6'b001101;
      K_LUI:   opcode = 6'b001111;
      K_LW:    opcode = 6'b100011;
      K_SW:    opcode = 6'b101011;
      K_BEQ:   opcode = 6'b000100;
      K_J:     opcode = 6'b000010;
      K_JAL:   opcode = 6'b000011;
      default: opcode = 6'b111111;
    endcase
  endtask

  function automatic int exp_pcw(kind_e k);
`ifdef ILLEGAL_TRAP_EN
    if (k == K_ILL) return 0;
`endif
    return (k == K_ILL) ? 1 : 1;
  endfunction

  // Expected cycle-by-cycle controls for one instruction, from the instruction table.
  function automatic void build(kind_e k, int iw, int dw);
    ctl_t c;
    trace.delete();
    for (int i = 0; i < iw; i++) begin
      c = '0; c.imem_req = 1'b1;
      push(c, 1'b0, rb());
    end
    c = '0; c.imem_req = 1'b1; c.ir_wr = 1'b1;
    push(c, 1'b1, rb());
    c = '0; c.state = 3'd1;
    case (k)
      K_J:   begin c.pc_wr = 1'b1; c.npc_sel = 3'b011; push(c, rb(), rb()); return; end
      K_JR:  begin c.pc_wr = 1'b1; c.npc_sel = 3'b100; push(c, rb(), rb()); return; end
      K_JAL: begin
        c.reg_wr = 1'b1; c.reg_dst = 2'b10; c.wd_sel = 2'b10;
        c.pc_wr = 1'b1; c.npc_sel = 3'b010;
        push(c, rb(), rb()); return;
      end
      K_ILL: begin
`ifdef ILLEGAL_TRAP_EN
        push(c, rb(), rb());
        c = '0; c.state = 3'd7; c.halted = 1'b1;
        push(c, rb(), rb());
        push(c, rb(), rb());
`else
        c.pc_wr = 1'b1; c.npc_sel = 3'b000;
        push(c, rb(), rb());
`endif
        return;
      end
      default: push(c, rb(), rb());
    endcase
    c = '0; c.state = 3'd2;
    case (k)
      K_ADDU: c.alu_op = 2'b00;
      K_SUBU: c.alu_op = 2'b01;
      K_ORI:  begin c.alu_src = 1'b1; c.alu_op = 2'b10; end
      K_LUI:  begin c.alu_src = 1'b1; c.alu_op = 2'b11; end
      K_LW, K_SW: begin c.alu_src = 1'b1; c.ext_op = 1'b1; end
      K_BEQ:  begin
        c.alu_op = 2'b01; c.pc_wr = 1'b1; c.npc_sel = 3'b001;
        push(c, rb(), rb()); return;
      end
      default: ;
    endcase
    push(c, rb(), rb());
    if (k == K_LW || k == K_SW) begin
      c = '0; c.state = 3'd3; c.dmem_req = 1'b1; c.mem_wr = (k == K_SW);
      for (int i = 0; i < dw; i++) push(c, rb(), 1'b0);
      if (k == K_SW) begin
        c.pc_wr = 1'b1;
        push(c, rb(), 1'b1);
        return;
      end
      push(c, rb(), 1'b1);
    end
    c = '0; c.state = 3'd4; c.reg_wr = 1'b1; c.pc_wr = 1'b1;
    c.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
    c.wd_sel  = (k == K_LW) ? 2'b01 : 2'b00;
    push(c, rb(), rb());
  endfunction

  // Plays the first n steps of the trace; entered and left just after a rising edge.
  task automatic run_steps(input string tag, input int n, output int pcw);
    pcw = 0;
    for (int i = 0; i < n; i++) begin
      imem_ready = trace[i].iready;
      dmem_ready = trace[i].dready;
      @(negedge clk);
      if (pc_wr) pcw++;
      check($sformatf("%s.step%0d", tag, i), 32'(observe()), 32'(trace[i].exp));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_instr(input kind_e k, input int iw, input int dw, input string tag);
    int pcw;
    set_ir(k);
    build(k, iw, dw);
    run_steps(tag, trace.size(), pcw);
    check({tag, ".pc_wr_count"}, 32'(pcw), 32'(exp_pcw(k)));
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      imem_ready = rb(); dmem_ready = rb();
      @(negedge clk);
      check("reset_outputs", 32'(observe()), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ctl_t c;
    int   pcw;
    kind_e kinds[10] = '{K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL};
    rst = 1'b1; opcode = '0; funct = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(2);

    do_instr(K_ADDU, 0, 0, "addu");
    do_instr(K_LW,   0, 3, "lw_wait3");
    do_instr(K_BEQ,  1, 0, "beq");
    do_instr(K_JAL,  0, 0, "jal");
    do_instr(K_JR,   2, 0, "jr");
    do_instr(K_SW,   0, 0, "sw");
    do_instr(K_ORI,  0, 0, "ori");
    do_instr(K_LUI,  3, 0, "lui");

    for (int n = 0; n < 40; n++) begin
      kind_e k;
      k = kinds[$urandom_range(0, 9)];
`ifndef ILLEGAL_TRAP_EN
      if ($urandom_range(0, 9) == 0) k = K_ILL;
`endif
      do_instr(k, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
    end

    // sw abandoned by reset while waiting in MEM
    set_ir(K_SW);
    build(K_SW, 0, 2);
    run_steps("sw_rst", 4, pcw);
    rst = 1'b1; dmem_ready = 1'b1; imem_ready = 1'b0;
    @(negedge clk);
    check("sw_rst.mem_wr", 32'(mem_wr), 32'd0);
    check("sw_rst.pc_wr", 32'(pc_wr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // imem_ready stuck low: four waiting FETCH cycles, then HALT with bus_err
    for (int i = 0; i < int'(WAIT_MAX); i++) begin
      imem_ready = 1'b0; dmem_ready = rb();
      @(negedge clk);
      c = '0; c.imem_req = 1'b1;
      check($sformatf("timeout.fetch%0d", i), 32'(observe()), 32'(c));
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b1; dmem_ready = rb();
      @(negedge clk);
      c = '0; c.state = 3'd7; c.halted = 1'b1; c.bus_err = 1'b1;
      check($sformatf("timeout.halt%0d", i), 32'(observe()), 32'(c));
      @(posedge clk); #1;
    end
    do_reset(1);

    // illegal opcode; its first FETCH step also confirms bus_err cleared
    do_instr(K_ILL, 0, 0, "illegal");
`ifdef ILLEGAL_TRAP_EN
    do_reset(1);
`endif
    do_instr(K_LW, 1, 2, "lw_after");
    do_instr(K_SUBU, 0, 0, "subu_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multicycle control FSM for the MIPS-lite datapath. Sequences each instruction through FETCH/DECODE/EXE/MEM/WB and drives the datapath control fields. Issues exactly one pc_wr per instruction and selects the next-PC source via npc_sel for the next-PC unit. Handshakes with instruction and data memory through req/ready pairs.

Parameters:
WAIT_MAX, 0, max cycles a memory request may wait for ready; 0 = unlimited (timeout logic removed)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
opcode  in  6  IR[31:26], valid from DECODE onward (IR loaded by ir_wr)
funct  in  6  IR[5:0], same validity
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access complete this cycle
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
ir_wr  out  1  load IR
pc_wr  out  1  load PC from next-PC unit
npc_sel  out  3  000 pc+4, 001 beq (gated by zero in next-PC unit), 010 jal, 011 j, 100 jr
reg_wr  out  1  register file write
reg_dst  out  2  00 rt, 01 rd, 10 $31
wd_sel  out  2  write-data source: 00 ALU, 01 memory, 10 pc+4
alu_src  out  1  0 rt, 1 extended immediate
alu_op  out  2  00 add, 01 sub, 10 or, 11 lui
ext_op  out  1  0 zero-extend, 1 sign-extend
mem_wr  out  1  data memory write
state  out  3  current state (FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4, HALT=7)
halted  out  1  FSM in HALT
bus_err  out  1  sticky; memory wait exceeded WAIT_MAX

Behaviour:
- clk is the only clock; rst is synchronous, active-high. During a reset cycle all outputs are 0; the next state is FETCH and bus_err clears.
- State is registered; outputs are combinational from state, opcode and funct. Outputs not listed for a state are 0.
- FETCH: imem_req=1. If imem_ready, ir_wr=1 and go to DECODE; otherwise stay in FETCH.
- DECODE:
  - j: pc_wr=1, npc_sel=011, go to FETCH.
  - jr (opcode 0, funct 001000): pc_wr=1, npc_sel=100, go to FETCH.
  - jal: reg_wr=1, reg_dst=10, wd_sel=10, pc_wr=1, npc_sel=010, go to FETCH.
  - All other legal instructions go to EXE.
- EXE:
  - addu (funct 100001): alu_op=00. subu (funct 100011): alu_op=01. Both go to WB.
  - ori: alu_src=1, ext_op=0, alu_op=10, go to WB.
  - lui: alu_src=1, alu_op=11, go to WB.
  - lw/sw: alu_src=1, ext_op=1, alu_op=00, go to MEM.
  - beq: alu_op=01, pc_wr=1, npc_sel=001, go to FETCH. pc_wr asserts regardless of zero; the next-PC unit gates the branch.
- MEM: dmem_req=1. For sw, mem_wr=1 throughout MEM.
  - sw with dmem_ready: pc_wr=1, npc_sel=000, go to FETCH.
  - lw with dmem_ready: go to WB.
  - Otherwise stay in MEM.
- WB: reg_wr=1, pc_wr=1, npc_sel=000, go to FETCH.
  - R-type: reg_dst=01, wd_sel=00.
  - ori/lui: reg_dst=00, wd_sel=00.
  - lw: reg_dst=00, wd_sel=01.
- Opcodes: R 000000, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- Latency: j/jr/jal 2 cycles; beq 3; R/ori/lui 4; sw 4+waits; lw 5+waits (waits = cycles before ready).
- Timeout (WAIT_MAX>0): a wait counter resets on entry to FETCH/MEM and increments each cycle ready is low. If it reaches WAIT_MAX: bus_err=1 (sticky), go to HALT, no pc_wr.
- HALT: all controls 0, halted=1. Exited only by rst.
- Reset mid-operation: any in-flight access is abandoned; no pc_wr or reg_wr in the reset cycle.
- Invariant: at most one pc_wr per instruction, and always in that instruction's final state.

Optional Feature:
ILLEGAL_TRAP_EN:
- Defined: an unrecognised opcode/funct in DECODE goes to HALT with halted=1.
- Undefined: it executes as a NOP. DECODE asserts pc_wr=1, npc_sel=000 and returns to FETCH; no register or memory write.

Test Plan:
- rst held 2 cycles, then imem_ready=1 with addu -> states 0,1,2,4; WB: reg_wr=1, reg_dst=01, pc_wr=1, npc_sel=000; one pc_wr total.
- lw, dmem_ready low 3 cycles -> MEM held 4 cycles with dmem_req=1; WB wd_sel=01; total 8 cycles.
- beq (zero-independent) -> EXE pc_wr=1, npc_sel=001, alu_op=01; FETCH the next cycle.
- jal -> DECODE reg_wr=1, reg_dst=10, wd_sel=10, npc_sel=010, pc_wr=1 in one cycle. jr -> npc_sel=100.
- sw with rst asserted during MEM -> mem_wr and pc_wr both 0 that cycle; state=FETCH next cycle.
- WAIT_MAX=4, imem_ready stuck low -> bus_err=1 and halted=1 after 4 waits. Opcode 111111 -> HALT with ILLEGAL_TRAP_EN defined, otherwise pc_wr=1/npc_sel=000 in DECODE.
